// File: rtl/core_pkg.sv
// Shared constants and state encoding for the SUBLEQ memory subsystem.
package core_pkg;
   localparam int DATA_W = 32;
   localparam logic [31:0] OUT_ADDR  = 32'hFFFF_FFFC;
   localparam logic [31:0] HALT_ADDR = 32'hFFFF_FFF8;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;
endpackage

// File: rtl/core_out_fifo.sv
// Output word FIFO toward the host; head served from the storage array.
module core_out_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [DATA_W-1:0]        i_data,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [AW:0]       r_cnt;
   logic              w_pop;
   logic              w_push;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_count = r_cnt;
   assign o_data  = r_mem[r_rd];
   assign w_pop   = i_pop & ~o_empty;
   // a pop frees the slot the same cycle, so a full FIFO still takes the push
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

// File: rtl/core_mem.sv
// Word RAM, byte-serial boot loader, MMIO output FIFO and halt control
// sitting directly behind the SUBLEQ core.
module core_mem
   import core_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        core_rst,
   input  logic        mem_rd_en,
   input  logic [31:0] mem_rd_addr,
   output logic [31:0] mem_rd_data,
   input  logic        mem_wr_en,
   input  logic [31:0] mem_wr_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [7:0]  load_byte,
   input  logic        load_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        halted,
   output logic        overflow
);
   state_t              r_state;
   logic                r_core_rst;
   logic                r_load_ready;
   logic                r_halted;
   logic                r_overflow;
   logic [ADDR_W:0]     r_ptr;
   logic [1:0]          r_lane;
   logic [DATA_W-1:0]   r_asm;
   logic [DATA_W-1:0]   r_ram [2**ADDR_W];

   logic                w_load_acc;
   logic                w_word_done;
   logic                w_ptr_full;
   logic [DATA_W-1:0]   w_asm_word;
   logic                w_run;
   logic                w_wr_in;
   logic                w_rd_in;
   logic                w_core_we;
   logic                w_push;
   logic                w_halt;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic                w_drop;
   logic                w_ram_we;
   logic [ADDR_W-1:0]   w_ram_addr;
   logic [DATA_W-1:0]   w_ram_data;
   logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
   logic                w_unused;

   assign w_load_acc  = load_valid & r_load_ready;
   assign w_word_done = w_load_acc & ((r_lane == 2'd3) | load_last);
   assign w_ptr_full  = r_ptr[ADDR_W];
   assign w_asm_word  = r_asm | (DATA_W'(load_byte) << {r_lane, 3'b000});

   assign w_run     = (r_state == S_RUN);
   assign w_wr_in   = (mem_wr_addr[31:ADDR_W+2] == '0);
   assign w_rd_in   = (mem_rd_addr[31:ADDR_W+2] == '0);
   assign w_core_we = w_run & mem_wr_en & w_wr_in;
   assign w_push    = w_run & mem_wr_en & (mem_wr_addr == OUT_ADDR);
   assign w_halt    = w_run & mem_wr_en & (mem_wr_addr == HALT_ADDR);
   assign w_pop     = out_valid & out_ready;
   assign w_drop    = w_push & w_full & ~w_pop;

   // loader and core never write in the same state, so one port suffices
   assign w_ram_we   = (w_word_done & ~w_ptr_full) | w_core_we;
   assign w_ram_addr = w_core_we ? mem_wr_addr[ADDR_W+1:2]
                                 : r_ptr[ADDR_W-1:0];
   assign w_ram_data = w_core_we ? mem_wr_data : w_asm_word;

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_addr] <= w_ram_data;
   end

   assign mem_rd_data = w_rd_in ? r_ram[mem_rd_addr[ADDR_W+1:2]] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_LOAD;
         r_core_rst   <= 1'b1;
         r_load_ready <= 1'b0;
         r_halted     <= 1'b0;
         r_overflow   <= 1'b0;
         r_ptr        <= '0;
         r_lane       <= '0;
         r_asm        <= '0;
      end else begin
         if (w_drop | (w_word_done & w_ptr_full)) r_overflow <= 1'b1;
         case (r_state)
            S_LOAD: begin
               r_load_ready <= 1'b1;
               if (w_load_acc) begin
                  if (w_word_done) begin
                     r_lane <= '0;
                     r_asm  <= '0;
                     if (!w_ptr_full) r_ptr <= r_ptr + 1'b1;
                  end else begin
                     r_lane <= r_lane + 2'd1;
                     r_asm  <= w_asm_word;
                  end
                  if (load_last) begin
                     r_state      <= S_RUN;
                     r_core_rst   <= 1'b0;
                     r_load_ready <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (w_halt) begin
                  r_state    <= S_HALT;
                  r_core_rst <= 1'b1;
                  r_halted   <= 1'b1;
               end
            end
            S_HALT: r_state <= S_HALT;
            default: r_state <= S_LOAD;
         endcase
      end
   end

   core_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (mem_wr_data),
      .o_data  (out_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_fifo_count)
   );

   assign out_valid  = ~w_empty;
   assign core_rst   = r_core_rst;
   assign load_ready = r_load_ready;
   assign halted     = r_halted;
   assign overflow   = r_overflow;
   assign w_unused   = ^{mem_rd_en, mem_rd_addr[1:0], w_fifo_count};
endmodule

// File: tb/tb_core_mem.sv
// Directed and randomized checks of core_mem against a queue/array model.
module tb_core_mem;
   localparam logic [31:0] OUT_A  = 32'hFFFF_FFFC;
   localparam logic [31:0] HALT_A = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_rst;
   logic        mem_rd_en = 1'b0;
   logic [31:0] mem_rd_addr = '0;
   logic [31:0] mem_rd_data;
   logic        mem_wr_en = 1'b0;
   logic [31:0] mem_wr_addr = '0;
   logic [31:0] mem_wr_data = '0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [7:0]  load_byte = '0;
   logic        load_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        halted;
   logic        overflow;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mram [int];
   logic [31:0] fq [$];
   logic [7:0]  img [$];
   logic        movf = 1'b0;
   bit          running = 1'b0;

   core_mem dut (
      .clk         (clk),
      .rst         (rst),
      .core_rst    (core_rst),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_byte   (load_byte),
      .load_last   (load_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .halted      (halted),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply the effect of the upcoming clock edge to the model.
   function automatic void model_edge();
      if (fq.size() > 0 && out_ready) void'(fq.pop_front());
      if (running && mem_wr_en) begin
         if (mem_wr_addr < 32'h1000)
            mram[int'(mem_wr_addr >> 2)] = mem_wr_data;
         else if (mem_wr_addr == OUT_A) begin
            if (fq.size() < 4) fq.push_back(mem_wr_data);
            else movf = 1'b1;
         end else if (mem_wr_addr == HALT_A)
            running = 1'b0;
      end
   endfunction

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_load();
      for (int i = 0; i < img.size(); i++) begin
         int w = i / 4;
         int l = i % 4;
         if (w < 1024) begin
            if (l == 0) mram[w] = 32'h0;
            mram[w] = mram[w] | (32'(img[i]) << (8 * l));
         end
      end
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      load_valid = 1'b0;
      load_last = 1'b0;
      mem_wr_en = 1'b0;
      out_ready = 1'b0;
      fq.delete();
      movf = 1'b0;
      running = 1'b0;
      #1;
      chk("rst_core_rst", core_rst, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_load_ready", load_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("load_ready_up", load_ready, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      load_valid = 1'b1;
      load_byte = b;
      load_last = last;
      while (!load_ready && n < 8) begin
         cyc();
         n++;
      end
      chk("load_ready_wait", load_ready, 1);
      cyc();
      load_valid = 1'b0;
      load_last = 1'b0;
      if (last) running = 1'b1;
   endtask

   task automatic load_img();
      model_load();
      for (int i = 0; i < img.size(); i++)
         send_byte(img[i], i == img.size() - 1);
   endtask

   task automatic core_wr(input logic [31:0] a, input logic [31:0] d);
      mem_wr_en = 1'b1;
      mem_wr_addr = a;
      mem_wr_data = d;
      cyc();
      mem_wr_en = 1'b0;
   endtask

   task automatic rd_chk(input logic [31:0] a);
      mem_rd_addr = a;
      #1;
      if (a >= 32'h1000) chk("rd_oor", mem_rd_data, 0);
      else if (mram.exists(int'(a >> 2)))
         chk("rd_ram", mem_rd_data, mram[int'(a >> 2)]);
   endtask

   task automatic fifo_chk();
      chk("out_valid", out_valid, fq.size() != 0);
      if (fq.size() != 0) chk("out_data", out_data, fq[0]);
      chk("overflow", overflow, movf);
   endtask

   initial begin
      #2;
      // Load 8 bytes; core_rst must fall right after the last accept.
      do_reset();
      img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      model_load();
      for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0);
      chk("core_rst_pre", core_rst, 1);
      send_byte(img[7], 1'b1);
      chk("core_rst_post", core_rst, 0);
      chk("load_ready_run", load_ready, 0);
      mem_rd_addr = 32'h0; #1;
      chk("ram0_a", mem_rd_data, 32'h04030201);
      mem_rd_addr = 32'h4; #1;
      chk("ram1_a", mem_rd_data, 32'h08070605);

      // Partial last word is zero-padded.
      do_reset();
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      load_img();
      mem_rd_addr = 32'h0; #1;
      chk("ram0_b", mem_rd_data, 32'hDDCCBBAA);
      mem_rd_addr = 32'h4; #1;
      chk("ram1_b", mem_rd_data, 32'h000000EE);

      core_wr(32'h10, 32'h1234);
      mem_rd_addr = 32'h10; #1;
      chk("rd_0x10", mem_rd_data, 32'h1234);
      mem_rd_addr = 32'h13; #1;
      chk("rd_0x13", mem_rd_data, 32'h1234);
      mem_rd_addr = 32'h0001_0000; #1;
      chk("rd_oor_fix", mem_rd_data, 32'h0);
      chk("run_halted", halted, 0);

      // Randomized RUN traffic.
      for (int it = 0; it < 400; it++) begin
         int r = int'($urandom_range(0, 9));
         int s = int'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) == 0);
         mem_wr_en = 1'b0;
         if (r <= 3) begin
            mem_wr_en = 1'b1;
            mem_wr_addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            mem_wr_data = $urandom;
         end else if (r <= 5) begin
            mem_wr_en = 1'b1;
            mem_wr_addr = OUT_A;
            mem_wr_data = $urandom;
         end else if (r == 6) begin
            mem_wr_en = 1'b1;
            mem_wr_addr = 32'h0001_0000 | 32'($urandom_range(0, 15) * 4);
            mem_wr_data = $urandom;
         end
         if (s == 0) rd_chk(32'h0000_4000 | 32'($urandom_range(0, 63)));
         else if (s == 1) rd_chk(OUT_A);
         else rd_chk(32'($urandom_range(0, 63)));
         fifo_chk();
         cyc();
      end
      mem_wr_en = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 8 && fq.size() != 0; n++) begin
         fifo_chk();
         cyc();
      end
      fifo_chk();
      for (int w = 0; w < 16; w++) rd_chk(32'(w * 4));

      // FIFO overflow with no pops, then ordered drain.
      do_reset();
      img = '{8'h11, 8'h22, 8'h33, 8'h44};
      load_img();
      out_ready = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         core_wr(OUT_A, 32'(v));
         if (v == 4) chk("ovf_at_4", overflow, 0);
      end
      chk("ovf_at_5", overflow, 1);
      out_ready = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, 32'(v));
         cyc();
      end
      chk("drain_empty", out_valid, 0);

      // Halt freezes RAM while the FIFO still drains.
      out_ready = 1'b0;
      core_wr(OUT_A, 32'h77);
      core_wr(HALT_A, 32'h0);
      chk("halted", halted, 1);
      chk("halt_core_rst", core_rst, 1);
      core_wr(32'h0, 32'hDEAD_BEEF);
      core_wr(OUT_A, 32'h55);
      mem_rd_addr = 32'h0; #1;
      chk("halt_ram0", mem_rd_data, 32'h44332211);
      fifo_chk();
      out_ready = 1'b1;
      cyc();
      chk("halt_drained", out_valid, 0);

      // Reset mid-run with an entry pending.
      do_reset();
      img = '{8'h55, 8'h66, 8'h77, 8'h88};
      load_img();
      out_ready = 1'b0;
      core_wr(OUT_A, 32'h99);
      fifo_chk();
      do_reset();
      mem_rd_addr = 32'h0; #1;
      chk("retain_ram0", mem_rd_data, 32'h88776655);

      // Image one byte larger than the RAM.
      img.delete();
      for (int i = 0; i < 4097; i++) img.push_back(8'((i * 7 + 3) & 255));
      model_load();
      for (int i = 0; i < 4096; i++) send_byte(img[i], 1'b0);
      chk("big_ovf_pre", overflow, 0);
      send_byte(img[4096], 1'b1);
      chk("big_ovf_post", overflow, 1);
      chk("big_core_rst", core_rst, 0);
      rd_chk(32'h0);
      rd_chk(32'h4);
      rd_chk(32'hFFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/core_mem.md
Name: core_mem

Overview:
- Memory subsystem directly downstream of the SUBLEQ core.
- Serves the core's combinational read port and its write port from a word RAM.
- Boots the RAM from a byte-serial host load stream while holding the core in reset.
- Exposes two memory-mapped addresses: an output FIFO toward the host, and a halt register that stops the core.

Parameters:
- ADDR_W, 10, word-address bits; RAM depth 2^ADDR_W 32-bit words.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- core_rst  out  1  active-high reset to core; 1 in LOAD and HALT
- mem_rd_en  in  1  core read request
- mem_rd_addr  in  32  core read byte address
- mem_rd_data  out  32  read data, combinational from mem_rd_addr, same cycle
- mem_wr_en  in  1  core write strobe
- mem_wr_addr  in  32  core write byte address
- mem_wr_data  in  32  core write data
- load_valid  in  1  host byte valid
- load_ready  out  1  host byte accepted when valid&ready
- load_byte  in  8  program byte, little-endian within word
- load_last  in  1  marks final byte of image
- out_valid  out  1  output FIFO non-empty
- out_ready  in  1  host pops on valid&ready
- out_data  out  32  FIFO head word
- halted  out  1  core halted
- overflow  out  1  sticky: output write dropped, or load image exceeded RAM

Behaviour:
- Reset (rst=0, async):
  - State=LOAD, core_rst=1, load pointer=0, byte lane=0, FIFO empty.
  - out_valid=0, halted=0, overflow=0, load_ready=0 during reset.
  - RAM contents are not cleared. Reset mid-load or mid-run restarts at LOAD.
- Addressing:
  - Word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
  - In range means addr[31:ADDR_W+2]==0.
  - MMIO constants: OUT_ADDR=32'hFFFF_FFFC, HALT_ADDR=32'hFFFF_FFF8.
- FSM LOAD -> RUN -> HALT; HALT exits only via reset.
- LOAD:
  - load_ready=1.
  - Each accepted byte goes into lane 0..3 of the assembly register.
  - Lane-3 accept writes the word to RAM[ptr] on that clock edge; ptr++ and lane=0.
  - load_last on an accepted byte writes the partial word (unfilled upper lanes=0), then enters RUN next cycle.
  - ptr saturates at 2^ADDR_W: further words are dropped and overflow=1; bytes are still accepted.
  - Core port is ignored in LOAD.
- RUN:
  - core_rst=0 starting the first cycle after the final load write.
  - Read, in range: mem_rd_data=RAM[index], combinational.
  - Read, otherwise: mem_rd_data=0. MMIO reads return 0.
  - mem_rd_data is a function of address only; mem_rd_en is not required to gate it.
  - Write, in range: RAM[index]<=mem_wr_data on the edge.
  - Write to OUT_ADDR: push mem_wr_data to the FIFO.
  - FIFO full and no pop this cycle: the push is dropped, overflow=1.
  - Full with a simultaneous pop: the push is accepted.
  - Write to HALT_ADDR: next cycle state=HALT, core_rst=1, halted=1.
  - Other out-of-range writes are ignored.
- HALT: RAM and the core port are frozen; the FIFO keeps draining to the host.
- FIFO:
  - Registered head; push to empty gives out_valid=1 next cycle.
  - Pop on out_valid&out_ready.
  - Simultaneous push and pop on empty: push stored, out_valid=1 next cycle.
- overflow is sticky until reset.

Decomposition:
- Package core_pkg: OUT_ADDR, HALT_ADDR, state encoding (LOAD=0, RUN=1, HALT=2), data width constant 32.
- Sub-module core_out_fifo (DEPTH param; push/pop/full/empty/count), instantiated once.
- RAM array, loader and FSM stay in core_mem.

Test Plan:
- Load 8 bytes 01 02 03 04 05 06 07 08, last on byte 8 -> RAM[0]=32'h04030201, RAM[1]=32'h08070605; core_rst falls exactly one cycle after the 8th byte accept.
- Load 5 bytes AA BB CC DD EE, last on byte 5 -> RAM[1]=32'h000000EE; ptr ends at 2.
- RUN: write 32'h1234 to addr 0x10, read addr 0x10 next cycle -> 32'h1234; read 0x13 -> same word; read 0x0001_0000 -> 0.
- Five writes to OUT_ADDR (values 1..5) with out_ready=0, FIFO_DEPTH=4 -> FIFO holds 1..4, overflow=1; out_ready=1 -> out_data 1,2,3,4 in order, then out_valid=0.
- Write to HALT_ADDR -> next cycle halted=1, core_rst=1; a subsequent write to 0x0 leaves RAM[0] unchanged.
- rst=0 mid-RUN with a FIFO entry pending -> immediately out_valid=0, core_rst=1, state LOAD; RAM[0] retains its previous value.
